dmem_arbiter: RTL and testbench

- Shares the single-port synchronous data memory (512 x 32, 1-cycle registered read) between two requesters: requester 0 = core load/store unit, requester 1 = debug/program-loader port.
- Round-robin arbitration with a bounded lock for atomic multi-beat sequences.
- Routes read data back to the owning requester one cycle after acceptance.
- Sits between the requesters and the data memory; the memory array itself is a sub-module.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_sp_ram.sv | 26 ++
 rtl/dmem_arbiter.sv | 152 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and types for the data-memory arbiter.
// Requester 0 is the core LSU, requester 1 the debug/program loader.
package dmem_pkg;

  localparam int DEF_ADDR_W   = 9;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_LOCK_MAX = 16;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic                  lock;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_sp_ram.sv
// dmem_sp_ram: single-port synchronous RAM, 2**ADDR_W x DATA_W.
// Read data is registered, one cycle after the enabled access.
module dmem_sp_ram #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter with bounded lock in front of the
// shared data RAM; routes read data back to the owning requester.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic              r0_lock,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic              r1_lock,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              lock_err
);

  localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  req_t              req [2];
  req_t              cur;
  logic [1:0]        req_v;
  logic [1:0]        gnt;
  logic              sel;
  logic              acc;

  arb_state_t        state_q;
  arb_state_t        state_d;
  logic              lock_owner;
  logic              owner_d;
  logic [CNT_W-1:0]  lock_cnt;
  logic [CNT_W-1:0]  cnt_d;
  logic              rr_ptr;
  logic              rr_d;
  logic              err_d;
  logic              rd_pending;
  logic              rd_owner;
  logic [DATA_W-1:0] mem_rdata;

  assign req[REQ_CORE] = '{we: r0_we, lock: r0_lock,
                           addr: r0_addr, wdata: r0_wdata};
  assign req[REQ_DBG]  = '{we: r1_we, lock: r1_lock,
                           addr: r1_addr, wdata: r1_wdata};

  assign req_v = {r1_req, r0_req};

  // Grant: lock owner exclusive, else round-robin on contention.
  always_comb begin
    gnt = '0;
    if (!resetn) begin
      gnt = '0;
    end else if (state_q == LOCKED) begin
      gnt[lock_owner] = req_v[lock_owner];
    end else if (&req_v) begin
      gnt[rr_ptr] = 1'b1;
    end else begin
      gnt = req_v;
    end
  end

  assign sel = gnt[REQ_DBG];
  assign acc = |gnt;
  assign cur = req[sel];

  always_comb begin
    state_d = state_q;
    owner_d = lock_owner;
    cnt_d   = lock_cnt;
    rr_d    = rr_ptr;
    err_d   = lock_err;
    unique case (state_q)
      IDLE: begin
        if (acc && cur.lock) begin
          state_d = LOCKED;
          owner_d = sel;
          cnt_d   = '0;
        end else if (acc) begin
          rr_d = ~sel;
        end
      end
      LOCKED: begin
        cnt_d = lock_cnt + 1'b1;
        if (!req[lock_owner].lock) begin
          state_d = IDLE;
          cnt_d   = '0;
          rr_d    = ~lock_owner;
        end else if (lock_cnt == CNT_LAST) begin
          // Timeout: hand priority to the other side and flag it.
          state_d = IDLE;
          cnt_d   = '0;
          rr_d    = ~lock_owner;
          err_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      lock_owner <= REQ_CORE;
      lock_cnt   <= '0;
      rr_ptr     <= REQ_CORE;
      lock_err   <= 1'b0;
      rd_pending <= 1'b0;
      rd_owner   <= REQ_CORE;
    end else begin
      state_q    <= state_d;
      lock_owner <= owner_d;
      lock_cnt   <= cnt_d;
      rr_ptr     <= rr_d;
      lock_err   <= err_d;
      rd_pending <= acc & ~cur.we;
      rd_owner   <= sel;
    end
  end

  dmem_sp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .en    (acc),
    .we    (acc & cur.we),
    .addr  (cur.addr),
    .wdata (cur.wdata),
    .rdata (mem_rdata)
  );

  assign r0_gnt    = gnt[REQ_CORE];
  assign r1_gnt    = gnt[REQ_DBG];
  assign r0_rvalid = resetn & rd_pending & (rd_owner == REQ_CORE);
  assign r1_rvalid = resetn & rd_pending & (rd_owner == REQ_DBG);
  assign r0_rdata  = mem_rdata;
  assign r1_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios for dmem_arbiter.
// Inputs change at negedge; outputs are sampled 1ns later.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        r0_req, r0_we, r0_lock;
  logic [8:0]  r0_addr;
  logic [31:0] r0_wdata;
  logic        r0_gnt, r0_rvalid;
  logic [31:0] r0_rdata;
  logic        r1_req, r1_we, r1_lock;
  logic [8:0]  r1_addr;
  logic [31:0] r1_wdata;
  logic        r1_gnt, r1_rvalid;
  logic [31:0] r1_rdata;
  logic        lock_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk       (clk),
    .resetn    (resetn),
    .r0_req    (r0_req),
    .r0_we     (r0_we),
    .r0_lock   (r0_lock),
    .r0_addr   (r0_addr),
    .r0_wdata  (r0_wdata),
    .r0_gnt    (r0_gnt),
    .r0_rvalid (r0_rvalid),
    .r0_rdata  (r0_rdata),
    .r1_req    (r1_req),
    .r1_we     (r1_we),
    .r1_lock   (r1_lock),
    .r1_addr   (r1_addr),
    .r1_wdata  (r1_wdata),
    .r1_gnt    (r1_gnt),
    .r1_rvalid (r1_rvalid),
    .r1_rdata  (r1_rdata),
    .lock_err  (lock_err)
  );

  task automatic set0(input logic req, input logic we, input logic lock,
                      input logic [8:0] addr, input logic [31:0] wdata);
    r0_req = req; r0_we = we; r0_lock = lock;
    r0_addr = addr; r0_wdata = wdata;
  endtask

  task automatic set1(input logic req, input logic we, input logic lock,
                      input logic [8:0] addr, input logic [31:0] wdata);
    r1_req = req; r1_we = we; r1_lock = lock;
    r1_addr = addr; r1_wdata = wdata;
  endtask

  task automatic test_reset();
    @(negedge clk);
    set0(1, 0, 0, 9'h001, 0);
    set1(1, 0, 0, 9'h002, 0);
    #1;
    n_cmp++;
    if ({r0_gnt, r1_gnt} !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_gnt: got %b exp 00", {r0_gnt, r1_gnt});
    end
    n_cmp++;
    if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_rvalid: got %b exp 00", {r0_rvalid, r1_rvalid});
    end
    n_cmp++;
    if (lock_err !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_lock_err: got %b exp 0", lock_err);
    end
    @(negedge clk);
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    resetn = 1'b1;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    set0(1, 1, 0, 9'h010, 32'hDEADBEEF);
    #1;
    n_cmp++;
    if (r0_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL wr_gnt: got %b exp 1", r0_gnt);
    end
    @(negedge clk);
    set0(1, 0, 0, 9'h010, 0);
    #1;
    n_cmp++;
    if ({r0_gnt, r0_rvalid} !== 2'b10) begin
      n_bad++;
      $display("FAIL rd_gnt: got gnt,rvalid=%b exp 10", {r0_gnt, r0_rvalid});
    end
    @(negedge clk);
    set0(0, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if ({r0_rvalid, r1_rvalid} !== 2'b10) begin
      n_bad++;
      $display("FAIL rd_rvalid: got %b exp 10", {r0_rvalid, r1_rvalid});
    end
    n_cmp++;
    if (r0_rdata !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL rd_data: got %h exp deadbeef", r0_rdata);
    end
    // Preload words used by the following scenarios via requester 1.
    @(negedge clk);
    set1(1, 1, 0, 9'h001, 32'h11111111);
    @(negedge clk);
    set1(1, 1, 0, 9'h002, 32'h22222222);
    #1;
    n_cmp++;
    if (r1_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL r1_wr_gnt: got %b exp 1", r1_gnt);
    end
    @(negedge clk);
    set1(0, 0, 0, 0, 0);
  endtask

  task automatic test_round_robin();
    logic eg0, eg1, ev0, ev1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      set0(k < 4, 0, 0, 9'h001, 0);
      set1(k < 4, 0, 0, 9'h002, 0);
      #1;
      eg0 = (k < 4) && (k % 2 == 0);
      eg1 = (k < 4) && (k % 2 == 1);
      ev0 = (k >= 1) && ((k - 1) % 2 == 0);
      ev1 = (k >= 1) && ((k - 1) % 2 == 1);
      n_cmp++;
      if ({r0_gnt, r1_gnt} !== {eg0, eg1}) begin
        n_bad++;
        $display("FAIL rr_gnt[%0d]: got %b exp %b", k,
                 {r0_gnt, r1_gnt}, {eg0, eg1});
      end
      n_cmp++;
      if ({r0_rvalid, r1_rvalid} !== {ev0, ev1}) begin
        n_bad++;
        $display("FAIL rr_rvalid[%0d]: got %b exp %b", k,
                 {r0_rvalid, r1_rvalid}, {ev0, ev1});
      end
      if (ev0) begin
        n_cmp++;
        if (r0_rdata !== 32'h11111111) begin
          n_bad++;
          $display("FAIL rr_data0[%0d]: got %h exp 11111111", k, r0_rdata);
        end
      end
      if (ev1) begin
        n_cmp++;
        if (r1_rdata !== 32'h22222222) begin
          n_bad++;
          $display("FAIL rr_data1[%0d]: got %h exp 22222222", k, r1_rdata);
        end
      end
    end
  endtask

  task automatic test_lock_release();
    logic eg0, eg1, ev0, ev1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      set1(k < 4, 0, k < 4, 9'h002, 0);
      set0(k >= 1 && k < 6, 0, 0, 9'h001, 0);
      #1;
      eg0 = (k == 5);
      eg1 = (k < 4);
      ev0 = (k == 6);
      ev1 = (k >= 1) && (k <= 4);
      n_cmp++;
      if ({r0_gnt, r1_gnt} !== {eg0, eg1}) begin
        n_bad++;
        $display("FAIL lk_gnt[%0d]: got %b exp %b", k,
                 {r0_gnt, r1_gnt}, {eg0, eg1});
      end
      n_cmp++;
      if ({r0_rvalid, r1_rvalid} !== {ev0, ev1}) begin
        n_bad++;
        $display("FAIL lk_rvalid[%0d]: got %b exp %b", k,
                 {r0_rvalid, r1_rvalid}, {ev0, ev1});
      end
      n_cmp++;
      if (lock_err !== 1'b0) begin
        n_bad++;
        $display("FAIL lk_err[%0d]: got %b exp 0", k, lock_err);
      end
    end
  endtask

  task automatic test_lock_timeout();
    logic eg0, eg1, ee;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      set0(k <= 17, 0, 1, 9'h001, 0);
      set1(k >= 1 && k <= 17, 0, 0, 9'h002, 0);
      #1;
      eg0 = (k <= 16);
      eg1 = (k == 17);
      ee  = (k >= 17);
      n_cmp++;
      if ({r0_gnt, r1_gnt} !== {eg0, eg1}) begin
        n_bad++;
        $display("FAIL to_gnt[%0d]: got %b exp %b", k,
                 {r0_gnt, r1_gnt}, {eg0, eg1});
      end
      n_cmp++;
      if (lock_err !== ee) begin
        n_bad++;
        $display("FAIL to_err[%0d]: got %b exp %b", k, lock_err, ee);
      end
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    set0(1, 0, 0, 9'h001, 0);
    set1(0, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if (r0_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL mr_gnt0: got %b exp 1", r0_gnt);
    end
    // r1 takes a locked read; rr pointer now favours r1.
    @(negedge clk);
    set0(0, 0, 0, 0, 0);
    set1(1, 0, 1, 9'h002, 0);
    #1;
    n_cmp++;
    if (r1_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL mr_gnt1: got %b exp 1", r1_gnt);
    end
    @(negedge clk);
    resetn = 1'b0;
    set1(0, 0, 0, 0, 0);
    set0(1, 1, 0, 9'h010, 32'h0BAD0BAD);
    #1;
    n_cmp++;
    if (r1_rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL mr_rvalid_rst: got %b exp 0", r1_rvalid);
    end
    n_cmp++;
    if (r0_gnt !== 1'b0) begin
      n_bad++;
      $display("FAIL mr_gnt_rst: got %b exp 0", r0_gnt);
    end
    @(negedge clk);
    resetn = 1'b1;
    set0(1, 0, 0, 9'h001, 0);
    set1(1, 0, 0, 9'h002, 0);
    #1;
    n_cmp++;
    if ({r0_gnt, r1_gnt} !== 2'b10) begin
      n_bad++;
      $display("FAIL mr_first: got %b exp 10", {r0_gnt, r1_gnt});
    end
    n_cmp++;
    if (lock_err !== 1'b0) begin
      n_bad++;
      $display("FAIL mr_err_clr: got %b exp 0", lock_err);
    end
    @(negedge clk);
    set0(1, 0, 0, 9'h010, 0);
    set1(0, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if ({r0_rvalid, r1_rvalid} !== 2'b10) begin
      n_bad++;
      $display("FAIL mr_rvalid: got %b exp 10", {r0_rvalid, r1_rvalid});
    end
    n_cmp++;
    if (r0_rdata !== 32'h11111111) begin
      n_bad++;
      $display("FAIL mr_data: got %h exp 11111111", r0_rdata);
    end
    @(negedge clk);
    set0(0, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if (r0_rdata !== 32'hDEADBEEF || r0_rvalid !== 1'b1) begin
      n_bad++;
      $display("FAIL mr_nowrite: got %h/%b exp deadbeef/1",
               r0_rdata, r0_rvalid);
    end
  endtask

  initial begin
    resetn = 1'b0;
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    test_reset();
    test_write_read();
    test_round_robin();
    test_lock_release();
    test_lock_timeout();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
